// File: rtl/ray_tri_sequencer_if.sv
// Ray/triangle sequencer bus: ray FIFO read side, triangle memory port, intersection FIFO write side.
// Latency: none, signal bundle only; triangle memory data is expected one cycle after tri_addr.
// Backpressure: out_full stalls the sequencer; in_empty (first-word fall-through) gates ray pops.
interface ray_tri_sequencer_if #(
    parameter int D_BITS = 32,
    parameter int M_BITS = 12
);
    // ray FIFO (first-word fall-through)
    logic                     in_empty;
    logic                     in_rd_en;
    logic [2:0][D_BITS-1:0]   ray_origin;
    logic [2:0][D_BITS-1:0]   ray_dir;
    logic                     ray_last;

    // triangle memory
    logic [M_BITS-1:0]        tri_addr;
    logic [2:0][D_BITS-1:0]   tri_v0;
    logic [2:0][D_BITS-1:0]   tri_v1;
    logic [2:0][D_BITS-1:0]   tri_v2;

    // intersection input FIFO
    logic                     out_full;
    logic                     out_wr_en;
    logic [2:0][D_BITS-1:0]   out_origin;
    logic [2:0][D_BITS-1:0]   out_dir;
    logic [2:0][D_BITS-1:0]   out_v0;
    logic [2:0][D_BITS-1:0]   out_v1;
    logic [2:0][D_BITS-1:0]   out_v2;
    logic [M_BITS-1:0]        out_triangle_ID;
    logic                     out_dummy;

    // sequencer side
    modport master (
        input  in_empty, ray_origin, ray_dir, ray_last,
        input  tri_v0, tri_v1, tri_v2,
        input  out_full,
        output in_rd_en, tri_addr,
        output out_wr_en, out_origin, out_dir, out_v0, out_v1, out_v2,
        output out_triangle_ID, out_dummy
    );

    // environment side (FIFOs and triangle memory)
    modport slave (
        output in_empty, ray_origin, ray_dir, ray_last,
        output tri_v0, tri_v1, tri_v2,
        output out_full,
        input  in_rd_en, tri_addr,
        input  out_wr_en, out_origin, out_dir, out_v0, out_v1, out_v2,
        input  out_triangle_ID, out_dummy
    );
endinterface

// File: rtl/ray_tri_sequencer.sv
// Pops one ray, fetches triangles 0..NUM_TRI-1 and writes one {ray, triangle, ID} record each.
// Latency: 3 cycles per triangle unstalled (FETCH, EMIT, ADV); ray pop adds IDLE+LATCH.
// Backpressure: out_full holds the FSM in EMIT/FLUSH; no write is issued while full. Macro RAY_TRI_SEQ_FLUSH_EN adds the dummy flush record after a last ray.
module ray_tri_sequencer #(
    parameter int D_BITS   = 32,
    parameter int M_BITS   = 12,
    parameter int NUM_TRI  = 16,
    parameter int RAY_BITS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    ray_tri_sequencer_if.master  bus,
    output logic                 busy,
    output logic [RAY_BITS-1:0]  ray_count
);

    localparam logic [M_BITS-1:0] LAST_ID = M_BITS'(NUM_TRI - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_FETCH,
        S_EMIT,
        S_ADV,
        S_DONE
`ifdef RAY_TRI_SEQ_FLUSH_EN
        , S_FLUSH
`endif
    } state_t;

    state_t                  state;
    logic                    in_rd_en_q;
    logic                    out_wr_en_q;
    logic [M_BITS-1:0]       id_q;
    logic [M_BITS-1:0]       tri_addr_q;
    logic [2:0][D_BITS-1:0]  origin_q;
    logic [2:0][D_BITS-1:0]  dir_q;
    logic [2:0][D_BITS-1:0]  v0_q;
    logic [2:0][D_BITS-1:0]  v1_q;
    logic [2:0][D_BITS-1:0]  v2_q;
    logic [M_BITS-1:0]       tri_id_q;
`ifdef RAY_TRI_SEQ_FLUSH_EN
    logic                    last_q;
    logic                    dummy_q;
`endif

    // Sequencer FSM: one ray in flight, one triangle record per FETCH/EMIT/ADV round.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            in_rd_en_q  <= 1'b0;
            out_wr_en_q <= 1'b0;
            id_q        <= '0;
            tri_addr_q  <= '0;
            origin_q    <= '0;
            dir_q       <= '0;
            v0_q        <= '0;
            v1_q        <= '0;
            v2_q        <= '0;
            tri_id_q    <= '0;
            ray_count   <= '0;
`ifdef RAY_TRI_SEQ_FLUSH_EN
            last_q      <= 1'b0;
            dummy_q     <= 1'b0;
`endif
        end else begin
            // both strobes are single-cycle pulses unless re-armed below
            in_rd_en_q  <= 1'b0;
            out_wr_en_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!bus.in_empty) begin
                        in_rd_en_q <= 1'b1;
                        state      <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    // FWFT head is still the popped ray on this edge
                    origin_q   <= bus.ray_origin;
                    dir_q      <= bus.ray_dir;
`ifdef RAY_TRI_SEQ_FLUSH_EN
                    last_q     <= bus.ray_last;
`endif
                    id_q       <= '0;
                    tri_addr_q <= '0;
                    state      <= S_FETCH;
                end
                S_FETCH: begin
                    // memory read latency of one cycle
                    state <= S_EMIT;
                end
                S_EMIT: begin
                    // re-registered every stalled cycle; address is unchanged so data is too
                    v0_q     <= bus.tri_v0;
                    v1_q     <= bus.tri_v1;
                    v2_q     <= bus.tri_v2;
                    tri_id_q <= id_q;
`ifdef RAY_TRI_SEQ_FLUSH_EN
                    dummy_q  <= 1'b0;
`endif
                    if (!bus.out_full) begin
                        out_wr_en_q <= 1'b1;
                        state       <= S_ADV;
                    end
                end
                S_ADV: begin
                    if (id_q == LAST_ID) begin
                        ray_count <= ray_count + 1'b1;
                        state     <= S_DONE;
                    end else begin
                        id_q       <= id_q + 1'b1;
                        tri_addr_q <= id_q + 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_DONE: begin
`ifdef RAY_TRI_SEQ_FLUSH_EN
                    state <= last_q ? S_FLUSH : S_IDLE;
`else
                    state <= S_IDLE;
`endif
                end
`ifdef RAY_TRI_SEQ_FLUSH_EN
                S_FLUSH: begin
                    // ID 0 terminator makes the accumulator emit the frame's last result
                    if (!bus.out_full) begin
                        out_wr_en_q <= 1'b1;
                        tri_id_q    <= '0;
                        dummy_q     <= 1'b1;
                        dir_q       <= '0;
                        v0_q        <= '0;
                        v1_q        <= '0;
                        v2_q        <= '0;
                        state       <= S_IDLE;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Interface drive from the registered state
    assign bus.in_rd_en        = in_rd_en_q;
    assign bus.tri_addr        = tri_addr_q;
    assign bus.out_wr_en       = out_wr_en_q;
    assign bus.out_origin      = origin_q;
    assign bus.out_dir         = dir_q;
    assign bus.out_v0          = v0_q;
    assign bus.out_v1          = v1_q;
    assign bus.out_v2          = v2_q;
    assign bus.out_triangle_ID = tri_id_q;
`ifdef RAY_TRI_SEQ_FLUSH_EN
    assign bus.out_dummy       = dummy_q;
`else
    assign bus.out_dummy       = 1'b0;
`endif

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ray_tri_sequencer.sv
// Bench for ray_tri_sequencer: NUM_TRI=4 instance with a ray FIFO and triangle memory model, plus NUM_TRI=1 instance.
// Latency: records timestamped by cycle to check 3-cycle spacing.
// Backpressure: out_full driven directly by the stall sequence.
module tb_ray_tri_sequencer;

    localparam int NT = 4;

    typedef logic [2:0][31:0] vec3_t;

    typedef struct {
        int          cyc;
        logic [11:0] id;
        vec3_t       v0, v1, v2, org, dir;
        logic        dummy;
    } rec_t;

    typedef struct {
        vec3_t org;
        vec3_t dir;
        bit    last;
    } ray_t;

    typedef struct {
        vec3_t org;
        vec3_t dir;
        bit    last;
        int    exp_recs;
        int    exp_count;
    } vec_t;

`ifdef RAY_TRI_SEQ_FLUSH_EN
    localparam int FLUSH_RECS = 1;
`else
    localparam int FLUSH_RECS = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        busy4, busy1;
    logic [15:0] rc4, rc1;

    ray_tri_sequencer_if #(.D_BITS(32), .M_BITS(12)) bus ();
    ray_tri_sequencer_if #(.D_BITS(32), .M_BITS(12)) bus1 ();

    ray_tri_sequencer #(.D_BITS(32), .M_BITS(12), .NUM_TRI(NT), .RAY_BITS(16)) dut (
        .clock(clock), .reset(reset), .bus(bus), .busy(busy4), .ray_count(rc4)
    );

    ray_tri_sequencer #(.D_BITS(32), .M_BITS(12), .NUM_TRI(1), .RAY_BITS(16)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1), .busy(busy1), .ray_count(rc1)
    );

    always #5 clock = ~clock;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   viol = 0;
    int   rd_pulses = 0;
    int   w1 = 0, bad1_id = 0, bad1_d = 0;
    rec_t rec_q[$];
    ray_t ray_q[$];
    vec_t tbl[4];

    function automatic vec3_t mk3(input int a, input int b, input int c);
        vec3_t v;
        v[0] = 32'(a);
        v[1] = 32'(b);
        v[2] = 32'(c);
        return v;
    endfunction

    // triangle memory contents: vertex k of triangle id, component c
    function automatic vec3_t tri_vert(input int id, input int k);
        vec3_t v;
        for (int c = 0; c < 3; c++) begin
            v[c] = (k == 1) ? 32'(-(id * 16 + k * 4 + c + 1)) : 32'(id * 16 + k * 4 + c + 1);
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_norm(input string tag, input rec_t r, input int eid, input vec3_t org, input vec3_t dir);
        chk({tag, "_id"},    r.id, eid);
        chk({tag, "_v0"},    r.v0, tri_vert(eid, 0));
        chk({tag, "_v1"},    r.v1, tri_vert(eid, 1));
        chk({tag, "_v2"},    r.v2, tri_vert(eid, 2));
        chk({tag, "_org"},   r.org, org);
        chk({tag, "_dir"},   r.dir, dir);
        chk({tag, "_dummy"}, r.dummy, 1'b0);
    endtask

    task automatic wait_count(input int exp, input string tag);
        int n = 0;
        while (!(rc4 == 16'(exp) && !busy4 && ray_q.size() == 0) && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (n >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: ray_count %0d busy %0d, required %0d idle", tag, rc4, busy4, exp);
        end
        repeat (4) @(negedge clock);
    endtask

    // cycle counter
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // ray FIFO (FWFT) and one-cycle-latency triangle memory for the NUM_TRI=4 instance
    initial begin
        int          addr_s;
        logic        pop;
        bus.in_empty   = 1'b1;
        bus.ray_origin = '0;
        bus.ray_dir    = '0;
        bus.ray_last   = 1'b0;
        bus.tri_v0     = '0;
        bus.tri_v1     = '0;
        bus.tri_v2     = '0;
        forever begin
            @(negedge clock);
            addr_s = int'(bus.tri_addr);
            pop    = bus.in_rd_en;
            @(posedge clock);
            #1;
            bus.tri_v0 = tri_vert(addr_s, 0);
            bus.tri_v1 = tri_vert(addr_s, 1);
            bus.tri_v2 = tri_vert(addr_s, 2);
            if (pop) begin
                rd_pulses++;
                if (ray_q.size() > 0) void'(ray_q.pop_front());
            end
            bus.in_empty = (ray_q.size() == 0);
            if (ray_q.size() > 0) begin
                bus.ray_origin = ray_q[0].org;
                bus.ray_dir    = ray_q[0].dir;
                bus.ray_last   = ray_q[0].last;
            end
        end
    end

    // write monitor for the NUM_TRI=4 instance
    initial begin
        logic full_s;
        rec_t r;
        forever begin
            @(posedge clock);
            full_s = bus.out_full;
            @(negedge clock);
            if (bus.out_wr_en) begin
                if (full_s) viol++;
                r.cyc   = cyc;
                r.id    = bus.out_triangle_ID;
                r.v0    = bus.out_v0;
                r.v1    = bus.out_v1;
                r.v2    = bus.out_v2;
                r.org   = bus.out_origin;
                r.dir   = bus.out_dir;
                r.dummy = bus.out_dummy;
                rec_q.push_back(r);
            end
        end
    end

    // write monitor for the NUM_TRI=1 instance
    initial forever begin
        @(negedge clock);
        if (bus1.out_wr_en) begin
            w1++;
            if (bus1.out_triangle_ID != 12'd0) bad1_id++;
            if (bus1.out_dummy) bad1_d++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        ray_t ry;
        int   base_rd;
        int   n;
        int   snap;

        tbl[0] = '{mk3(1, 2, 3),       mk3(4, -5, 6),  1'b0, NT,              1};
        tbl[1] = '{mk3(-7, 8, -9),     mk3(1, 1, 1),   1'b0, NT,              2};
        tbl[2] = '{mk3(7, 8, 9),       mk3(0, -3, 2),  1'b1, NT + FLUSH_RECS, 3};
        tbl[3] = '{mk3(100, -200, 300), mk3(5, 5, 5),  1'b0, NT,              4};

        bus.out_full     = 1'b0;
        bus1.out_full    = 1'b0;
        bus1.in_empty    = 1'b1;
        bus1.ray_origin  = '0;
        bus1.ray_dir     = mk3(0, 0, 1);
        bus1.ray_last    = 1'b0;
        bus1.tri_v0      = tri_vert(0, 0);
        bus1.tri_v1      = tri_vert(0, 1);
        bus1.tri_v2      = tri_vert(0, 2);

        // reset state
        #12;
        chk("rst_wr_en",  bus.out_wr_en, 1'b0);
        chk("rst_rd_en",  bus.in_rd_en, 1'b0);
        chk("rst_addr",   bus.tri_addr, 12'd0);
        chk("rst_id",     bus.out_triangle_ID, 12'd0);
        chk("rst_origin", bus.out_origin, 96'd0);
        chk("rst_v0",     bus.out_v0, 96'd0);
        chk("rst_dummy",  bus.out_dummy, 1'b0);
        chk("rst_busy",   busy4, 1'b0);
        chk("rst_count",  rc4, 16'd0);
        #10;
        reset = 1'b0;

        // table: one ray each, unstalled
        for (int i = 0; i < 4; i++) begin
            rec_q.delete();
            base_rd = rd_pulses;
            ry.org = tbl[i].org; ry.dir = tbl[i].dir; ry.last = tbl[i].last;
            ray_q.push_back(ry);
            wait_count(tbl[i].exp_count, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_nrec", i), rec_q.size(), tbl[i].exp_recs);
            chk($sformatf("tbl%0d_rdpulse", i), rd_pulses - base_rd, 1);
            chk($sformatf("tbl%0d_count", i), rc4, tbl[i].exp_count);
            chk($sformatf("tbl%0d_busy", i), busy4, 1'b0);
            for (int j = 0; j < rec_q.size() && j < tbl[i].exp_recs; j++) begin
                if (j < NT) begin
                    check_norm($sformatf("tbl%0d_r%0d", i, j), rec_q[j], j, tbl[i].org, tbl[i].dir);
                    if (j > 0) chk($sformatf("tbl%0d_r%0d_gap", i, j), rec_q[j].cyc - rec_q[j-1].cyc, 3);
                end else begin
                    chk($sformatf("tbl%0d_flush_id", i),    rec_q[j].id, 12'd0);
                    chk($sformatf("tbl%0d_flush_dummy", i), rec_q[j].dummy, 1'b1);
                    chk($sformatf("tbl%0d_flush_dir", i),   rec_q[j].dir, 96'd0);
                    chk($sformatf("tbl%0d_flush_v0", i),    rec_q[j].v0, 96'd0);
                    chk($sformatf("tbl%0d_flush_v2", i),    rec_q[j].v2, 96'd0);
                    chk($sformatf("tbl%0d_flush_org", i),   rec_q[j].org, tbl[i].org);
                end
            end
        end

        // two rays queued back-to-back
        rec_q.delete();
        base_rd = rd_pulses;
        ry.org = mk3(11, 12, 13); ry.dir = mk3(1, 0, 0); ry.last = 1'b0;
        ray_q.push_back(ry);
        ry.org = mk3(21, 22, 23); ry.dir = mk3(0, 1, 0); ry.last = 1'b0;
        ray_q.push_back(ry);
        wait_count(6, "b2b");
        chk("b2b_nrec", rec_q.size(), 2 * NT);
        chk("b2b_rdpulse", rd_pulses - base_rd, 2);
        chk("b2b_count", rc4, 16'd6);
        for (int j = 0; j < rec_q.size() && j < 2 * NT; j++) begin
            check_norm($sformatf("b2b_r%0d", j), rec_q[j], j % NT,
                       (j < NT) ? mk3(11, 12, 13) : mk3(21, 22, 23),
                       (j < NT) ? mk3(1, 0, 0) : mk3(0, 1, 0));
        end

        // back-pressure while ID 2 is pending
        rec_q.delete();
        ry.org = mk3(-1, -2, -3); ry.dir = mk3(9, 9, 9); ry.last = 1'b0;
        ray_q.push_back(ry);
        n = 0;
        while (!(bus.out_wr_en && bus.out_triangle_ID == 12'd1) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("stall_reach_id1", (n < 100), 1'b1);
        @(posedge clock);
        #1 bus.out_full = 1'b1;
        snap = rec_q.size();
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("stall_no_write", rec_q.size(), snap);
        chk("stall_busy", busy4, 1'b1);
        @(posedge clock);
        #1 bus.out_full = 1'b0;
        wait_count(7, "stall");
        chk("stall_nrec", rec_q.size(), NT);
        for (int j = 0; j < rec_q.size() && j < NT; j++) begin
            check_norm($sformatf("stall_r%0d", j), rec_q[j], j, mk3(-1, -2, -3), mk3(9, 9, 9));
        end

        // reset mid-ray at ID 1
        rec_q.delete();
        ry.org = mk3(31, 32, 33); ry.dir = mk3(2, 2, 2); ry.last = 1'b0;
        ray_q.push_back(ry);
        n = 0;
        while (!(bus.out_wr_en && bus.out_triangle_ID == 12'd1) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("mid_reach_id1", (n < 100), 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_wr_en",  bus.out_wr_en, 1'b0);
        chk("mid_rst_addr",   bus.tri_addr, 12'd0);
        chk("mid_rst_id",     bus.out_triangle_ID, 12'd0);
        chk("mid_rst_origin", bus.out_origin, 96'd0);
        chk("mid_rst_v1",     bus.out_v1, 96'd0);
        chk("mid_rst_busy",   busy4, 1'b0);
        chk("mid_rst_count",  rc4, 16'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("mid_no_write_after_rst", rec_q.size(), 2);
        rec_q.delete();
        ry.org = mk3(41, 42, 43); ry.dir = mk3(3, -3, 3); ry.last = 1'b0;
        ray_q.push_back(ry);
        wait_count(1, "mid");
        chk("mid_nrec", rec_q.size(), NT);
        chk("mid_count", rc4, 16'd1);
        for (int j = 0; j < rec_q.size() && j < NT; j++) begin
            check_norm($sformatf("mid_r%0d", j), rec_q[j], j, mk3(41, 42, 43), mk3(3, -3, 3));
        end

        // NUM_TRI=1 instance, three rays
        for (int k = 0; k < 3; k++) begin
            bus1.ray_origin = mk3(k + 1, 0, 0);
            bus1.in_empty   = 1'b0;
            n = 0;
            while (!bus1.in_rd_en && n < 50) begin
                @(negedge clock);
                n++;
            end
            chk($sformatf("nt1_pop%0d", k), (n < 50), 1'b1);
            @(posedge clock);
            #1 bus1.in_empty = 1'b1;
            n = 0;
            while (!(rc1 == 16'(k + 1) && !busy1) && n < 50) begin
                @(negedge clock);
                n++;
            end
            chk($sformatf("nt1_done%0d", k), (n < 50), 1'b1);
        end
        repeat (5) @(negedge clock);
        chk("nt1_writes", w1, 3);
        chk("nt1_nonzero_id", bad1_id, 0);
        chk("nt1_dummy", bad1_d, 0);
        chk("nt1_count", rc1, 16'd3);

        chk("wr_under_full", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ray_tri_sequencer.md
Name: ray_tri_sequencer

Overview:
- Front-end producer of the hit-accumulation stream.
- Pops one ray (origin, direction, last flag) from the ray FIFO and fetches every triangle from triangle memory, IDs 0..NUM_TRI-1 in order.
- Writes one {ray, triangle, triangle_ID} record per triangle into the intersection input FIFO.
- Triangle_ID 0 marks the start of each ray; the downstream min-distance accumulator relies on this to flush the previous ray. With the optional feature, a terminating dummy record flushes the final ray.

Parameters:
- D_BITS, 32, coordinate width (signed fixed point).
- M_BITS, 12, triangle_ID / triangle memory address width.
- NUM_TRI, 16, triangles per ray; legal range 1..2^M_BITS.
- RAY_BITS, 16, width of ray_count.

Ports:
- clock  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_empty  in  1  ray FIFO empty (FWFT: data valid while low).
- in_rd_en  out  1  ray FIFO pop.
- ray_origin  in  3 x D_BITS signed  ray origin.
- ray_dir  in  3 x D_BITS signed  ray direction.
- ray_last  in  1  last ray of frame.
- tri_addr  out  M_BITS  triangle memory address.
- tri_v0, tri_v1, tri_v2  in  3 x D_BITS signed each  vertices, valid 1 cycle after tri_addr.
- out_full  in  1  output FIFO full.
- out_wr_en  out  1  output FIFO write strobe.
- out_origin, out_dir  out  3 x D_BITS signed  ray of record.
- out_v0, out_v1, out_v2  out  3 x D_BITS signed  triangle of record.
- out_triangle_ID  out  M_BITS  triangle index.
- out_dummy  out  1  record is a flush marker.
- busy  out  1  high in any state other than IDLE.
- ray_count  out  RAY_BITS  rays fully issued since reset.

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; internal id 0; ray_count 0. Reset mid-ray abandons the ray with no further writes; the popped ray is lost.
- IDLE: if !in_empty, set in_rd_en=1 and go to LATCH; else hold.
- LATCH (in_rd_en high this cycle): clear in_rd_en. Capture ray_origin, ray_dir, ray_last into out_origin, out_dir and a last register. Set id=0, tri_addr=0, go to FETCH.
- FETCH: one-cycle memory wait; go to EMIT.
- EMIT:
  - Register out_v0/v1/v2 from tri_v*, out_triangle_ID=id, out_dummy=0.
  - If !out_full: pulse out_wr_en for exactly one cycle (the cycle after this edge).
  - If out_full: stall in EMIT, keep re-registering the same data, no write.
- After the write, in the cycle out_wr_en is high (ADV):
  - out_wr_en falls.
  - If id==NUM_TRI-1: ray_count++, go to DONE.
  - Else: id++, tri_addr=id+1, go to FETCH.
- Throughput: 3 cycles per triangle with no back-pressure. out_wr_en never asserts on a cycle where out_full was sampled high at the preceding edge.
- Record data is stable during the out_wr_en cycle.
- DONE: if the flush path applies (see Optional Feature), go to FLUSH; else go to IDLE.
- FLUSH: wait for !out_full, then write one record: triangle_ID 0, out_dummy=1, out_dir=0, out_v*=0, out_origin unchanged. Go to IDLE; ray_count is not incremented. Downstream must report hit=0 for dummy records.
- in_rd_en never asserts outside IDLE->LATCH; at most one ray in flight.
- NUM_TRI=1: every record carries triangle_ID 0.
- ray_count wraps modulo 2^RAY_BITS.

Optional Feature:
- Macro RAY_TRI_SEQ_FLUSH_EN.
- Defined: after the final triangle of a ray with ray_last=1, the FLUSH state emits the dummy terminator so the accumulator outputs the frame's final result.
- Undefined: the FLUSH state is not built, out_dummy is tied 0, and DONE always returns to IDLE; the final ray's result is emitted only when a later ray arrives.

Test Plan:
- NUM_TRI=4, one ray origin (1,2,3), out_full=0 -> 4 writes, IDs 0,1,2,3, each with the matching tri memory contents; writes 3 cycles apart; ray_count=1; busy low afterwards.
- Two rays queued back-to-back -> 8 writes, ID sequence 0,1,2,3,0,1,2,3; second ray's origin appears on record 4; in_rd_en pulses exactly twice.
- out_full held high for 5 cycles while in EMIT of ID 2 -> no write during the stall; exactly one ID 2 record after release; no duplicates or skipped IDs.
- Reset asserted mid-ray at ID 1 -> all outputs 0 immediately; after release with a new ray queued, records restart at ID 0.
- RAY_TRI_SEQ_FLUSH_EN defined, single ray with ray_last=1 -> 4 records plus a 5th record with ID 0, out_dummy=1, dir (0,0,0); ray_count=1. Macro undefined -> exactly 4 records.
- NUM_TRI=1, three rays -> three ID-0 records; ray_count=3.
